// File: rtl/neureka_weight_buffer.sv
// Weight stream buffer: tile-counted FIFO between the streamer and the engine.
// Optional NEUREKA_WEIGHT_BUFFER_LAST_EN adds a per-entry weight_o_last flag.
`ifndef NEUREKA_MEM_BANDWIDTH_EXT
`define NEUREKA_MEM_BANDWIDTH_EXT 288
`endif

module neureka_weight_buffer #(
   parameter int unsigned BW    = `NEUREKA_MEM_BANDWIDTH_EXT,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     start_i,
   input  logic [CNT_W-1:0]         nb_beats_i,
   input  logic                     weight_i_valid,
   output logic                     weight_i_ready,
   input  logic [BW-1:0]            weight_i_data,
   input  logic [BW/8-1:0]          weight_i_strb,
   output logic                     weight_o_valid,
   input  logic                     weight_o_ready,
   output logic [BW-1:0]            weight_o_data,
   output logic [BW/8-1:0]          weight_o_strb,
`ifdef NEUREKA_WEIGHT_BUFFER_LAST_EN
   output logic                     weight_o_last,
`endif
   output logic                     busy_o,
   output logic                     done_o,
   output logic [$clog2(DEPTH):0]   occupancy_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   remaining_q, remaining_d;
   logic [PTR_W-1:0]   wptr_q, rptr_q;
   logic [OCC_W-1:0]   occ_q, occ_d;
   logic               full_q;
   logic               push, pop;

   logic [BW-1:0]      data_mem [DEPTH];
   logic [BW/8-1:0]    strb_mem [DEPTH];
`ifdef NEUREKA_WEIGHT_BUFFER_LAST_EN
   logic               last_mem [DEPTH];
`endif

   // Ready comes from the registered full flag so a pop never opens a slot combinationally.
   assign weight_i_ready = (state_q == StStream) && !full_q;
   assign weight_o_valid = (occ_q != '0);
   assign push           = weight_i_valid && weight_i_ready;
   assign pop            = weight_o_valid && weight_o_ready;
   assign weight_o_data  = data_mem[rptr_q];
   assign weight_o_strb  = strb_mem[rptr_q];
`ifdef NEUREKA_WEIGHT_BUFFER_LAST_EN
   assign weight_o_last  = last_mem[rptr_q];
`endif
   assign busy_o         = (state_q != StIdle);
   assign occupancy_o    = occ_q;

   always_comb begin
      occ_d = occ_q;
      unique case ({push, pop})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_o      = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               if (nb_beats_i != '0) begin
                  remaining_d = nb_beats_i;
                  state_d     = StStream;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StStream: begin
            if (push) begin
               remaining_d = remaining_q - CNT_W'(1);
               if (remaining_q == CNT_W'(1)) state_d = StDrain;
            end
         end
         StDrain: begin
            if ((occ_q == '0) || ((occ_q == OCC_W'(1)) && pop)) state_d = StDone;
         end
         StDone: begin
            done_o  = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         state_q     <= StIdle;
         remaining_q <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         occ_q       <= '0;
         full_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         occ_q       <= occ_d;
         full_q      <= (occ_d == OCC_W'(DEPTH));
         if (push) wptr_q <= wptr_q + PTR_W'(1);
         if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      end
   end

   // Storage is deliberately left out of reset; the pointers alone define validity.
   always_ff @(posedge clk_i) begin
      if (push) begin
         data_mem[wptr_q] <= weight_i_data;
         strb_mem[wptr_q] <= weight_i_strb;
`ifdef NEUREKA_WEIGHT_BUFFER_LAST_EN
         last_mem[wptr_q] <= (remaining_q == CNT_W'(1));
`endif
      end
   end

endmodule
